// File: rtl/enoc_node_interface_if.sv
// Packet type and node/network handshake bundle for enoc_node_interface.
//   packet_t : routed packet payload (destination, source, data).
//   enoc_node_interface_if : all valid/enable channels of one node port.
//     slave  modport : the node interface block itself.
//     master modport : the environment (traffic node plus network local port).
package enoc_node_interface_pkg;
  typedef struct packed {
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [23:0] payload;
  } packet_t;
endpackage

interface enoc_node_interface_if;
  import enoc_node_interface_pkg::*;

  // Node -> TX FIFO
  packet_t i_pkt;
  logic    i_pkt_val;
  logic    o_pkt_en;
  // TX FIFO -> network local input
  packet_t o_net_data;
  logic    o_net_data_val;
  logic    i_net_en;
  // Network local output -> RX FIFO
  packet_t i_net_data;
  logic    i_net_data_val;
  logic    o_net_en;
  // RX FIFO -> node
  packet_t o_pkt;
  logic    o_pkt_val;
  logic    i_pkt_en;

  modport slave (
    input  i_pkt, i_pkt_val, i_net_en, i_net_data, i_net_data_val, i_pkt_en,
    output o_pkt_en, o_net_data, o_net_data_val, o_net_en, o_pkt, o_pkt_val
  );

  modport master (
    output i_pkt, i_pkt_val, i_net_en, i_net_data, i_net_data_val, i_pkt_en,
    input  o_pkt_en, o_net_data, o_net_data_val, o_net_en, o_pkt, o_pkt_val
  );
endinterface

// File: rtl/enoc_node_interface.sv
// Node-side interface to one ENoC local port: a TX FIFO (node -> network)
// and an RX FIFO (network -> node), both first-word-fall-through with the
// valid/enable protocol, plus per-path transfer counters.
//   clk, reset_n   : clock, synchronous active-low reset
//   bus (slave)    : node and network valid/enable channels
//   o_tx_count     : packets injected into the network (wraps)
//   o_rx_count     : packets delivered to the node (wraps)

// FWFT FIFO with valid/enable handshake on both sides. Enable and valid are
// decoded from the registered occupancy only (gated by reset), so a full FIFO
// refuses a write even when it is being read in the same cycle.
module enoc_node_interface_fifo
  import enoc_node_interface_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  packet_t wr_data,
  input  logic    wr_val,
  output logic    wr_en,
  output packet_t rd_data,
  output logic    rd_val,
  input  logic    rd_en,
  output logic    rd_fire
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  packet_t            mem_q [DEPTH];
  packet_t            mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               push;

  assign wr_en   = reset_n & (occ_q < OCC_W'(DEPTH));
  assign rd_val  = reset_n & (occ_q != '0);
  assign rd_data = rd_val ? mem_q[rd_ptr_q] : '0;
  assign push    = wr_val & wr_en;
  assign rd_fire = rd_val & rd_en;

  // Next-state: write at tail, pop at head, pointers wrap modulo DEPTH
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, rd_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state; emptying only needs pointers and occupancy cleared
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Packet storage, contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module enoc_node_interface
  import enoc_node_interface_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  enoc_node_interface_if.slave  bus,
  output logic [CNT_W-1:0]      o_tx_count,
  output logic [CNT_W-1:0]      o_rx_count
);
  logic             tx_fire, rx_fire;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;

  // Node -> network
  enoc_node_interface_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (bus.i_pkt),
    .wr_val  (bus.i_pkt_val),
    .wr_en   (bus.o_pkt_en),
    .rd_data (bus.o_net_data),
    .rd_val  (bus.o_net_data_val),
    .rd_en   (bus.i_net_en),
    .rd_fire (tx_fire)
  );

  // Network -> node
  enoc_node_interface_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (bus.i_net_data),
    .wr_val  (bus.i_net_data_val),
    .wr_en   (bus.o_net_en),
    .rd_data (bus.o_pkt),
    .rd_val  (bus.o_pkt_val),
    .rd_en   (bus.i_pkt_en),
    .rd_fire (rx_fire)
  );

  // Transfer counters, wrap naturally at 2^CNT_W
  always_comb begin
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    if (tx_fire) tx_count_d = tx_count_q + CNT_W'(1);
    if (rx_fire) rx_count_d = rx_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign o_tx_count = tx_count_q;
  assign o_rx_count = rx_count_q;
endmodule

// File: tb/tb_enoc_node_interface.sv
// Self-checking bench for enoc_node_interface: directed scenarios plus a
// randomized run, all checked against a queue-based packet model.
module tb_enoc_node_interface;
  import enoc_node_interface_pkg::*;

  localparam int TXD  = 4;
  localparam int RXD  = 4;
  localparam int CW   = 4;
  localparam int CMOD = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] tx_count, rx_count;

  enoc_node_interface_if bus();

  enoc_node_interface #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .o_tx_count (tx_count),
    .o_rx_count (rx_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: packet queues and transfer totals
  packet_t tx_m[$];
  packet_t rx_m[$];
  int      tx_cnt = 0;
  int      rx_cnt = 0;

  function automatic packet_t rand_pkt();
    return packet_t'($urandom);
  endfunction

  function automatic packet_t tx_head();
    packet_t p = packet_t'(0);
    if (tx_m.size() != 0) p = tx_m[0];
    return p;
  endfunction

  function automatic packet_t rx_head();
    packet_t p = packet_t'(0);
    if (rx_m.size() != 0) p = rx_m[0];
    return p;
  endfunction

  // One clock: model decides transfers from pre-edge state, then advances
  task automatic tick();
    bit tw, tr, rw, rr;
    packet_t tpk, rpk;
    tw  = reset_n && bus.i_pkt_val      && (tx_m.size() < TXD);
    tr  = reset_n && bus.i_net_en       && (tx_m.size() != 0);
    rw  = reset_n && bus.i_net_data_val && (rx_m.size() < RXD);
    rr  = reset_n && bus.i_pkt_en       && (rx_m.size() != 0);
    tpk = bus.i_pkt;
    rpk = bus.i_net_data;
    @(posedge clk);
    if (!reset_n) begin
      tx_m.delete();
      rx_m.delete();
      tx_cnt = 0;
      rx_cnt = 0;
    end else begin
      if (tr) begin void'(tx_m.pop_front()); tx_cnt = (tx_cnt + 1) % CMOD; end
      if (tw) tx_m.push_back(tpk);
      if (rr) begin void'(rx_m.pop_front()); rx_cnt = (rx_cnt + 1) % CMOD; end
      if (rw) rx_m.push_back(rpk);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.i_pkt          = packet_t'(0);
    bus.i_pkt_val      = 1'b0;
    bus.i_net_en       = 1'b0;
    bus.i_net_data     = packet_t'(0);
    bus.i_net_data_val = 1'b0;
    bus.i_pkt_en       = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.i_pkt = rand_pkt(); bus.i_pkt_val = 1'b1; bus.i_net_en = 1'b1;
    bus.i_net_data = rand_pkt(); bus.i_net_data_val = 1'b1; bus.i_pkt_en = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.o_pkt_en !== 1'b0) begin n_err++; $display("FAIL rst_pkt_en: got %b want 0", bus.o_pkt_en); end
    n_vec++; if (bus.o_net_en !== 1'b0) begin n_err++; $display("FAIL rst_net_en: got %b want 0", bus.o_net_en); end
    n_vec++; if (bus.o_net_data_val !== 1'b0) begin n_err++; $display("FAIL rst_net_val: got %b want 0", bus.o_net_data_val); end
    n_vec++; if (bus.o_pkt_val !== 1'b0) begin n_err++; $display("FAIL rst_pkt_val: got %b want 0", bus.o_pkt_val); end
    n_vec++; if (tx_count !== CW'(0)) begin n_err++; $display("FAIL rst_tx_count: got %0d want 0", tx_count); end
    n_vec++; if (rx_count !== CW'(0)) begin n_err++; $display("FAIL rst_rx_count: got %0d want 0", rx_count); end
    idle();
    reset_n = 1'b1;
    #1;
    n_vec++; if (bus.o_pkt_en !== 1'b1) begin n_err++; $display("FAIL rel_pkt_en: got %b want 1", bus.o_pkt_en); end
    n_vec++; if (bus.o_net_en !== 1'b1) begin n_err++; $display("FAIL rel_net_en: got %b want 1", bus.o_net_en); end
    n_vec++; if (bus.o_net_data_val !== 1'b0) begin n_err++; $display("FAIL rel_net_val: got %b want 0", bus.o_net_data_val); end
  endtask

  task automatic test_tx_fill();
    packet_t sent [4];
    idle();
    for (int i = 0; i < 4; i++) begin
      sent[i] = rand_pkt();
      bus.i_pkt = sent[i];
      bus.i_pkt_val = 1'b1;
      tick();
      n_vec++; if (bus.o_net_data_val !== 1'b1 || bus.o_net_data !== sent[0]) begin
        n_err++; $display("FAIL fill_head[%0d]: got val=%b data=%h want val=1 data=%h", i, bus.o_net_data_val, bus.o_net_data, sent[0]);
      end
      n_vec++; if (bus.o_pkt_en !== (i < 3)) begin
        n_err++; $display("FAIL fill_pkt_en[%0d]: got %b want %b", i, bus.o_pkt_en, (i < 3));
      end
    end
    // A fifth packet is offered while full and must be refused
    bus.i_pkt = rand_pkt();
    tick();
    bus.i_pkt_val = 1'b0;
    n_vec++; if (bus.o_pkt_en !== 1'b0) begin n_err++; $display("FAIL full_pkt_en: got %b want 0", bus.o_pkt_en); end
    bus.i_net_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.o_net_data_val !== 1'b1 || bus.o_net_data !== sent[i]) begin
        n_err++; $display("FAIL drain[%0d]: got val=%b data=%h want val=1 data=%h", i, bus.o_net_data_val, bus.o_net_data, sent[i]);
      end
      tick();
    end
    n_vec++; if (bus.o_net_data_val !== 1'b0 || bus.o_net_data !== packet_t'(0)) begin
      n_err++; $display("FAIL drain_empty: got val=%b data=%h want val=0 data=0", bus.o_net_data_val, bus.o_net_data);
    end
    n_vec++; if (tx_count !== CW'(4)) begin n_err++; $display("FAIL fill_tx_count: got %0d want 4", tx_count); end
    idle();
  endtask

  task automatic test_rx_stream();
    localparam int N = 20;
    packet_t sent [N];
    idle();
    bus.i_pkt_en = 1'b1;
    for (int c = 0; c < N + 2; c++) begin
      if (c < N) begin
        sent[c] = rand_pkt();
        bus.i_net_data = sent[c];
        bus.i_net_data_val = 1'b1;
      end else begin
        bus.i_net_data_val = 1'b0;
      end
      #1;
      n_vec++; if (bus.o_net_en !== 1'b1) begin n_err++; $display("FAIL stream_net_en[%0d]: got %b want 1", c, bus.o_net_en); end
      if (c >= 1 && c <= N) begin
        n_vec++; if (bus.o_pkt_val !== 1'b1 || bus.o_pkt !== sent[c-1]) begin
          n_err++; $display("FAIL stream_out[%0d]: got val=%b data=%h want val=1 data=%h", c, bus.o_pkt_val, bus.o_pkt, sent[c-1]);
        end
      end else begin
        n_vec++; if (bus.o_pkt_val !== 1'b0) begin n_err++; $display("FAIL stream_idle[%0d]: got val=%b want 0", c, bus.o_pkt_val); end
      end
      tick();
    end
    n_vec++; if (rx_count !== CW'(N % CMOD)) begin n_err++; $display("FAIL stream_rx_count: got %0d want %0d", rx_count, N % CMOD); end
    idle();
  endtask

  task automatic test_full_read();
    packet_t sent [4];
    int      seen;
    idle();
    for (int i = 0; i < 4; i++) begin
      sent[i] = rand_pkt();
      bus.i_net_data = sent[i];
      bus.i_net_data_val = 1'b1;
      tick();
    end
    // Still offering a packet while full, with one node-side pop
    bus.i_net_data = rand_pkt();
    bus.i_pkt_en = 1'b1;
    #1;
    n_vec++; if (bus.o_net_en !== 1'b0) begin n_err++; $display("FAIL fullrd_net_en: got %b want 0", bus.o_net_en); end
    n_vec++; if (bus.o_pkt !== sent[0]) begin n_err++; $display("FAIL fullrd_head: got %h want %h", bus.o_pkt, sent[0]); end
    tick();
    bus.i_net_data_val = 1'b0;
    #1;
    n_vec++; if (bus.o_net_en !== 1'b1) begin n_err++; $display("FAIL fullrd_net_en_after: got %b want 1", bus.o_net_en); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.o_pkt_val === 1'b1) begin
        if (seen < 3) begin
          n_vec++; if (bus.o_pkt !== sent[1+seen]) begin
            n_err++; $display("FAIL fullrd_drain[%0d]: got %h want %h", seen, bus.o_pkt, sent[1+seen]);
          end
        end
        seen++;
      end
      tick();
    end
    n_vec++; if (seen !== 3) begin n_err++; $display("FAIL fullrd_occ: got %0d packets want 3", seen); end
    idle();
  endtask

  task automatic test_counter_wrap();
    packet_t sent [17];
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    n_vec++; if (tx_count !== CW'(0)) begin n_err++; $display("FAIL wrap_start: got %0d want 0", tx_count); end
    bus.i_net_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sent[i] = rand_pkt();
      bus.i_pkt = sent[i];
      bus.i_pkt_val = 1'b1;
      tick();
      n_vec++; if (bus.o_net_data !== sent[i]) begin
        n_err++; $display("FAIL wrap_head[%0d]: got %h want %h", i, bus.o_net_data, sent[i]);
      end
    end
    bus.i_pkt_val = 1'b0;
    for (int k = 0; k < 8 && bus.o_net_data_val === 1'b1; k++) tick();
    n_vec++; if (bus.o_net_data_val !== 1'b0) begin n_err++; $display("FAIL wrap_drain_timeout: got val=%b want 0", bus.o_net_data_val); end
    n_vec++; if (tx_count !== CW'(1)) begin n_err++; $display("FAIL wrap_tx_count: got %0d want 1", tx_count); end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      bus.i_pkt          = rand_pkt();
      bus.i_pkt_val      = ($urandom_range(0, 3) != 0);
      bus.i_net_en       = ($urandom_range(0, 1) != 0);
      bus.i_net_data     = rand_pkt();
      bus.i_net_data_val = ($urandom_range(0, 3) != 0);
      bus.i_pkt_en       = ($urandom_range(0, 1) != 0);
      #1;
      n_vec++; if (bus.o_pkt_en !== (tx_m.size() < TXD)) begin n_err++; $display("FAIL rnd_pkt_en[%0d]: got %b want %b", c, bus.o_pkt_en, (tx_m.size() < TXD)); end
      n_vec++; if (bus.o_net_en !== (rx_m.size() < RXD)) begin n_err++; $display("FAIL rnd_net_en[%0d]: got %b want %b", c, bus.o_net_en, (rx_m.size() < RXD)); end
      n_vec++; if (bus.o_net_data_val !== (tx_m.size() != 0) || bus.o_net_data !== tx_head()) begin
        n_err++; $display("FAIL rnd_tx_out[%0d]: got val=%b data=%h want val=%b data=%h", c, bus.o_net_data_val, bus.o_net_data, (tx_m.size() != 0), tx_head());
      end
      n_vec++; if (bus.o_pkt_val !== (rx_m.size() != 0) || bus.o_pkt !== rx_head()) begin
        n_err++; $display("FAIL rnd_rx_out[%0d]: got val=%b data=%h want val=%b data=%h", c, bus.o_pkt_val, bus.o_pkt, (rx_m.size() != 0), rx_head());
      end
      n_vec++; if (tx_count !== CW'(tx_cnt) || rx_count !== CW'(rx_cnt)) begin
        n_err++; $display("FAIL rnd_counts[%0d]: got tx=%0d rx=%0d want tx=%0d rx=%0d", c, tx_count, rx_count, tx_cnt, rx_cnt);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mid_reset();
    idle();
    for (int i = 0; i < 2; i++) begin
      bus.i_pkt = rand_pkt(); bus.i_pkt_val = 1'b1;
      bus.i_net_data = rand_pkt(); bus.i_net_data_val = 1'b1;
      tick();
    end
    idle();
    #1;
    n_vec++; if (bus.o_net_data_val !== 1'b1 || bus.o_pkt_val !== 1'b1) begin
      n_err++; $display("FAIL mid_prefill: got tx_val=%b rx_val=%b want 1 1", bus.o_net_data_val, bus.o_pkt_val);
    end
    reset_n = 1'b0;
    bus.i_net_en = 1'b1;
    bus.i_pkt_en = 1'b1;
    #1;
    n_vec++; if (bus.o_net_data_val !== 1'b0 || bus.o_pkt_val !== 1'b0 || bus.o_pkt_en !== 1'b0 || bus.o_net_en !== 1'b0) begin
      n_err++; $display("FAIL mid_inreset: got tx_val=%b rx_val=%b pkt_en=%b net_en=%b want all 0", bus.o_net_data_val, bus.o_pkt_val, bus.o_pkt_en, bus.o_net_en);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (bus.o_net_data_val !== 1'b0 || bus.o_pkt_val !== 1'b0) begin
        n_err++; $display("FAIL mid_held_out[%0d]: got tx_val=%b rx_val=%b want 0 0", k, bus.o_net_data_val, bus.o_pkt_val);
      end
      n_vec++; if (tx_count !== CW'(0) || rx_count !== CW'(0)) begin
        n_err++; $display("FAIL mid_counts[%0d]: got tx=%0d rx=%0d want 0 0", k, tx_count, rx_count);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_tx_fill();
    test_rx_stream();
    test_full_read();
    test_counter_wrap();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
